// File: rtl/fifo_rd_pkg.sv
// Purpose: shared types and constants for the FIFO burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // Output skid depth: one word in flight from the FIFO plus one held word
   // is enough to keep 1 word/cycle through the FIFO's read latency.
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Purpose: command, FIFO read port and output stream of the burst reader.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
interface fifo_burst_reader_if #(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic [LEN_W-1:0]  cmd_len;
   logic              cmd_ready;

   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_data_out;
   logic              fifo_empty;
   logic              fifo_rd_ack;

   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_last;
   logic              m_ready;

   // Reader side: accepts commands, masters the FIFO read and output stream.
   modport master (
      input  cmd_valid, cmd_len, fifo_data_out, fifo_empty, fifo_rd_ack, m_ready,
      output cmd_ready, fifo_rd_en, m_data, m_valid, m_last
   );

   // Environment side: command source, FIFO and downstream consumer.
   modport slave (
      output cmd_valid, cmd_len, fifo_data_out, fifo_empty, fifo_rd_ack, m_ready,
      input  cmd_ready, fifo_rd_en, m_data, m_valid, m_last
   );
endinterface

// File: rtl/fifo_rd_skid.sv
// Purpose: 2-entry in-order buffer decoupling FIFO read data from the consumer.
// Latency: a word written in cycle N is presented on out_* in cycle N+1.
// Backpressure: no in_ready; the writer keeps occ+pending below depth.
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [OCC_W-1:0]  occ
);

   logic [DATA_W-1:0] data0_q, data1_q;
   logic              last0_q, last1_q;
   logic [OCC_W-1:0]  occ_q;
   logic              pop;

   assign pop       = out_valid && out_ready;
   assign out_valid = (occ_q != OCC_W'(0));
   assign out_data  = data0_q;
   assign out_last  = last0_q;
   assign occ       = occ_q;

   // Entry 0 is always the head; entry 1 shifts down on a pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data0_q <= '0;
         data1_q <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
         occ_q   <= '0;
      end else if (in_valid && pop) begin
         if (occ_q == OCC_W'(1)) begin
            data0_q <= in_data;
            last0_q <= in_last;
         end else begin
            data0_q <= data1_q;
            last0_q <= last1_q;
            data1_q <= in_data;
            last1_q <= in_last;
         end
      end else if (in_valid) begin
         if (occ_q == OCC_W'(0)) begin
            data0_q <= in_data;
            last0_q <= in_last;
            occ_q   <= OCC_W'(1);
         end else if (occ_q == OCC_W'(1)) begin
            data1_q <= in_data;
            last1_q <= in_last;
            occ_q   <= OCC_W'(SKID_DEPTH);
         end
      end else if (pop) begin
         data0_q <= data1_q;
         last0_q <= last1_q;
         occ_q   <= occ_q - OCC_W'(1);
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// Purpose: drains a burst of cmd_len words from a 1-cycle-latency FIFO to a valid/ready stream.
// Latency: cmd accepted in T -> first rd_en T+1, capture T+2, m_valid T+3; 1 word/cycle sustained.
// Backpressure: reads stop once buffered+in-flight words reach 2; no reads while fifo_empty.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   fifo_burst_reader_if.master bus,
   output logic                busy,
   output logic                done,
   output logic [LEN_W-1:0]    words_left,
   output logic                proto_err
);

   rd_state_t         state_q, state_d;
   logic [LEN_W-1:0]  issue_left_q;
   logic [LEN_W-1:0]  words_left_q;
   logic              pend_q;
   logic              pend_last_q;
   logic              done_q, done_d;
   logic              proto_err_q;

   logic              rd_en;
   logic              cmd_fire;
   logic              pop;
   logic [2:0]        room_sum;

   logic              skid_valid;
   logic              skid_last;
   logic [DATA_W-1:0] skid_data;
   logic [OCC_W-1:0]  skid_occ;

   assign pop      = skid_valid && bus.m_ready;
   assign cmd_fire = bus.cmd_valid && bus.cmd_ready;

   // Words that will sit in the buffer after this cycle if no new read is issued.
   assign room_sum = 3'(skid_occ) + 3'(pend_q) - 3'(pop);

   // Read only with data present, burst words left to issue and buffer room.
   always_comb begin
      rd_en = (state_q == BURST) && !bus.fifo_empty &&
              (issue_left_q != '0) && (room_sum < 3'(SKID_DEPTH));
   end

   // Next state, command handshake and done request.
   always_comb begin
      state_d       = state_q;
      done_d        = 1'b0;
      bus.cmd_ready = (state_q == IDLE);
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               if (bus.cmd_len != '0) state_d = BURST;
               else                   done_d  = 1'b1;
            end
         end
         BURST: begin
            if (issue_left_q == '0 || (rd_en && issue_left_q == LEN_W'(1)))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (words_left_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Burst counters, in-flight read tracking, done pulse and sticky protocol error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_left_q <= '0;
         words_left_q <= '0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         done_q       <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         done_q      <= done_d;
         pend_q      <= rd_en;
         pend_last_q <= rd_en && (issue_left_q == LEN_W'(1));
         if (rd_en && !bus.fifo_rd_ack) proto_err_q <= 1'b1;
         if (cmd_fire) begin
            issue_left_q <= bus.cmd_len;
            words_left_q <= bus.cmd_len;
         end else begin
            if (rd_en) issue_left_q <= issue_left_q - LEN_W'(1);
            if (pop && words_left_q != '0) words_left_q <= words_left_q - LEN_W'(1);
         end
      end
   end

   fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (pend_q),
      .in_data   (bus.fifo_data_out),
      .in_last   (pend_last_q),
      .out_valid (skid_valid),
      .out_ready (bus.m_ready),
      .out_data  (skid_data),
      .out_last  (skid_last),
      .occ       (skid_occ)
   );

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = skid_valid;
   assign bus.m_data     = skid_data;
   assign bus.m_last     = skid_last;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign words_left     = words_left_q;
   assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Purpose: scoreboard bench for fifo_burst_reader with a behavioural 1-cycle FIFO.
// Latency: checks first-read, first-valid and last-pop cycles of a basic burst.
// Backpressure: stalls m_ready and empties the FIFO mid-burst.
module tb_fifo_burst_reader;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy, done, proto_err;
   logic [7:0] words_left;
   logic       nack;

   fifo_burst_reader_if #(.DATA_W(16), .LEN_W(8)) bus ();

   fifo_burst_reader #(.DATA_W(16), .LEN_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .words_left (words_left),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: mem/wr_ptr written by the stimulus, rd_ptr by the read port.
   logic [15:0] mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   assign bus.fifo_empty  = (wr_ptr == rd_ptr);
   assign bus.fifo_rd_ack = bus.fifo_rd_en && !nack;

   initial bus.fifo_data_out = 16'h0;
   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         bus.fifo_data_out <= mem[rd_ptr[5:0]];
         rd_ptr            <= rd_ptr + 1;
      end
   end

   exp_t        exp_q[$];
   int          total = 0, bad = 0;
   int          cyc = 0;
   int          rd_cnt, pop_cnt, done_cnt, uf_cnt, busy_cnt;
   int          first_rd, last_rd, first_val, last_pop, acc_cyc, done_cyc;
   logic        acc_seen, done_seen, stall_prev;
   logic [15:0] prev_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      rd_cnt = 0; pop_cnt = 0; done_cnt = 0; uf_cnt = 0; busy_cnt = 0;
      first_rd = -1; last_rd = -1; first_val = -1; last_pop = -1;
      acc_cyc = -1; done_cyc = -1; acc_seen = 0; done_seen = 0;
   endtask

   task automatic fifo_push(input logic [15:0] d, input logic l);
      exp_t e;
      mem[wr_ptr[5:0]] = d;
      wr_ptr = wr_ptr + 1;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   // One clock: sample what the coming edge will do, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      #1;
      if (bus.fifo_rd_en) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
         if (bus.fifo_empty) uf_cnt++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
         acc_cyc  = cyc;
         acc_seen = 1;
      end
      if (done) begin
         done_cnt++;
         done_seen = 1;
         done_cyc  = cyc;
      end
      if (busy) busy_cnt++;
      if (bus.m_valid && first_val < 0) first_val = cyc;
      if (stall_prev) begin
         chk("hold_valid", 32'(bus.m_valid), 32'd1);
         chk("hold_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
         pop_cnt++;
         last_pop = cyc;
         if (exp_q.size() == 0) begin
            chk("sb_extra_word", 32'(bus.m_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_data", 32'(bus.m_data), 32'(e.d));
            chk("sb_last", 32'(bus.m_last), 32'(e.l));
         end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic send_cmd(input logic [7:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len;
      acc_seen      = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (acc_seen) break;
      end
      bus.cmd_valid = 1'b0;
      if (!acc_seen) chk("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int budget, input string tag);
      done_seen = 0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (done_seen) break;
      end
      chk(tag, 32'(done_seen), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      nack          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = 8'd0;
      bus.m_ready   = 1'b0;
      stall_prev    = 1'b0;
      prev_data     = 16'h0;
      clr_stats();

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("rst_busy_done", 32'({busy, done, proto_err}), 32'd0);
      chk("rst_words_left", 32'(words_left), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Basic burst: A0..A3, m_ready=1
      clr_stats();
      for (int i = 0; i < 4; i++) fifo_push(16'h00A0 + 16'(i), i == 3);
      bus.m_ready = 1'b1;
      send_cmd(8'd4);
      #1;
      chk("basic_words_left", 32'(words_left), 32'd4);
      chk("basic_busy", 32'(busy), 32'd1);
      wait_done(40, "basic_done");
      repeat (3) tick();
      chk("basic_first_rd", first_rd, acc_cyc + 1);
      chk("basic_last_rd", last_rd, acc_cyc + 4);
      chk("basic_rd_cnt", rd_cnt, 4);
      chk("basic_first_valid", first_val, acc_cyc + 3);
      chk("basic_last_pop", last_pop, acc_cyc + 6);
      chk("basic_pops", pop_cnt, 4);
      chk("basic_done_cnt", done_cnt, 1);
      chk("basic_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("basic_sb_empty", exp_q.size(), 0);

      // Backpressure: 6 words, consumer stalled 10 cycles
      clr_stats();
      for (int i = 0; i < 6; i++) fifo_push(16'h00B0 + 16'(i), i == 5);
      bus.m_ready = 1'b0;
      send_cmd(8'd6);
      repeat (10) tick();
      chk("bp_reads_stalled", rd_cnt, 2);
      chk("bp_words_left", 32'(words_left), 32'd6);
      bus.m_ready = 1'b1;
      wait_done(40, "bp_done");
      chk("bp_pops", pop_cnt, 6);
      chk("bp_sb_empty", exp_q.size(), 0);

      // FIFO empties mid-burst
      clr_stats();
      fifo_push(16'h00C0, 1'b0);
      fifo_push(16'h00C1, 1'b0);
      send_cmd(8'd5);
      repeat (8) tick();
      chk("empty_mid_reads", rd_cnt, 2);
      fifo_push(16'h00C2, 1'b0);
      fifo_push(16'h00C3, 1'b0);
      fifo_push(16'h00C4, 1'b1);
      wait_done(60, "empty_done");
      chk("empty_no_underflow", uf_cnt, 0);
      chk("empty_pops", pop_cnt, 5);
      chk("empty_proto_err", 32'(proto_err), 32'd0);

      // Zero-length command
      clr_stats();
      send_cmd(8'd0);
      wait_done(5, "zero_done");
      tick();
      chk("zero_done_cycle", done_cyc, acc_cyc + 1);
      chk("zero_rd_cnt", rd_cnt, 0);
      chk("zero_busy", busy_cnt, 0);
      chk("zero_words_left", 32'(words_left), 32'd0);

      // Protocol error: read without ack
      clr_stats();
      fifo_push(16'h00D0, 1'b1);
      nack = 1'b1;
      send_cmd(8'd1);
      wait_done(20, "proto_done");
      nack = 1'b0;
      chk("proto_err_set", 32'(proto_err), 32'd1);
      repeat (5) tick();
      chk("proto_err_sticky", 32'(proto_err), 32'd1);
      chk("proto_pops", pop_cnt, 1);

      // Reset mid-burst during the 3rd word
      clr_stats();
      for (int i = 0; i < 8; i++) fifo_push(16'h00E0 + 16'(i), i == 7);
      send_cmd(8'd8);
      for (int n = 0; n < 30 && pop_cnt < 2; n++) tick();
      chk("rstmid_reached_word3", pop_cnt, 2);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rstmid_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_words_left", 32'(words_left), 32'd0);
      chk("rstmid_proto_err", 32'(proto_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
      tick();
      chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rstmid_idle_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
